// File: rtl/handshake_rx_arbiter_if.sv
// Bundle between the sender array, the arbiter and the single four-phase receiver.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface handshake_rx_arbiter_if #(
  parameter int NUM_SENDERS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16
);
  localparam int ID_WIDTH = $clog2(NUM_SENDERS);

  logic [NUM_SENDERS-1:0]            sender_req;
  logic [NUM_SENDERS*DATA_WIDTH-1:0] sender_data;
  logic [NUM_SENDERS-1:0]            sender_ack;
  logic                              rx_enable;
  logic                              rx_ack;
  logic                              rx_req;
  logic [DATA_WIDTH-1:0]             rx_data;
  logic [ID_WIDTH-1:0]               grant_id;
  logic                              busy;
  logic [CNT_WIDTH-1:0]              xfer_count;

  modport master (
    output sender_req, sender_data, rx_enable, rx_ack,
    input  sender_ack, rx_req, rx_data, grant_id, busy, xfer_count
  );

  modport slave (
    input  sender_req, sender_data, rx_enable, rx_ack,
    output sender_ack, rx_req, rx_data, grant_id, busy, xfer_count
  );
endinterface

// File: rtl/handshake_rx_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack receiver among several senders.
// Latches the winner's data at grant and relays the handshake until release.
module handshake_rx_arbiter #(
  parameter int NUM_SENDERS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic reset,
  handshake_rx_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_SENDERS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_ACK_UP  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]             state_reg;
  logic [NUM_SENDERS-1:0] sender_ack_reg;
  logic                   rx_req_reg;
  logic [DATA_WIDTH-1:0]  rx_data_reg;
  logic [ID_WIDTH-1:0]    grant_id_reg;
  logic                   busy_reg;
  logic [CNT_WIDTH-1:0]   xfer_count_reg;
  logic [ID_WIDTH-1:0]    last_grant_reg;

  logic [ID_WIDTH-1:0]    winner;
  logic                   found;
  logic [DATA_WIDTH-1:0]  data_arr [NUM_SENDERS];

  for (genvar gi = 0; gi < NUM_SENDERS; gi++) begin : g_data
    assign data_arr[gi] = bus.sender_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from last_grant+N down to last_grant+1 so the nearest requester
  // after the previous winner is the one left standing.
  always_comb begin
    winner = last_grant_reg;
    found  = 1'b0;
    for (int k = NUM_SENDERS; k >= 1; k--) begin
      if (bus.sender_req[ID_WIDTH'((int'(last_grant_reg) + k) % NUM_SENDERS)]) begin
        winner = ID_WIDTH'((int'(last_grant_reg) + k) % NUM_SENDERS);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      sender_ack_reg <= '0;
      rx_req_reg     <= 1'b0;
      rx_data_reg    <= '0;
      grant_id_reg   <= '0;
      busy_reg       <= 1'b0;
      xfer_count_reg <= '0;
      last_grant_reg <= ID_WIDTH'(NUM_SENDERS - 1);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.rx_enable && !bus.rx_ack && found) begin
            grant_id_reg <= winner;
            rx_data_reg  <= data_arr[winner];
            rx_req_reg   <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.rx_ack) begin
            sender_ack_reg <= NUM_SENDERS'(1) << grant_id_reg;
            state_reg      <= ST_ACK_UP;
          end
        end
        ST_ACK_UP: begin
          if (!bus.sender_req[grant_id_reg]) begin
            rx_req_reg <= 1'b0;
            state_reg  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.rx_ack) begin
            sender_ack_reg <= '0;
            last_grant_reg <= grant_id_reg;
            xfer_count_reg <= xfer_count_reg + CNT_WIDTH'(1);
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          sender_ack_reg <= '0;
          rx_req_reg     <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sender_ack = sender_ack_reg;
  assign bus.rx_req     = rx_req_reg;
  assign bus.rx_data    = rx_data_reg;
  assign bus.grant_id   = grant_id_reg;
  assign bus.busy       = busy_reg;
  assign bus.xfer_count = xfer_count_reg;
endmodule

// File: tb/tb_handshake_rx_arbiter.sv
// Directed bench for handshake_rx_arbiter; a second instance with a 2-bit
// counter mirrors the same stimulus to exercise counter wrap.
module tb_handshake_rx_arbiter;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  handshake_rx_arbiter_if #(.NUM_SENDERS(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
  handshake_rx_arbiter_if #(.NUM_SENDERS(4), .DATA_WIDTH(8), .CNT_WIDTH(2))  bus2 ();

  assign bus2.sender_req  = bus.sender_req;
  assign bus2.sender_data = bus.sender_data;
  assign bus2.rx_enable   = bus.rx_enable;
  assign bus2.rx_ack      = bus.rx_ack;

  handshake_rx_arbiter #(.NUM_SENDERS(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  handshake_rx_arbiter #(.NUM_SENDERS(4), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Full transfer with zero-delay peers; caller has already raised sender_req[id].
  task automatic xfer(input int id, input logic [7:0] d);
    tick();
    check("grant_id", 32'(bus.grant_id), 32'(id));
    check("grant_data", 32'(bus.rx_data), 32'(d));
    check("grant_rx_req", 32'(bus.rx_req), 1);
    bus.rx_ack = 1'b1;
    tick();
    check("xfer_ack", 32'(bus.sender_ack), 32'(4'b0001 << id));
    check("ack_onehot", 32'($countones(bus.sender_ack) <= 1), 1);
    bus.sender_req[id] = 1'b0;
    tick();
    check("xfer_rx_req_low", 32'(bus.rx_req), 0);
    bus.rx_ack = 1'b0;
    tick();
    check("xfer_ack_low", 32'(bus.sender_ack), 0);
    check("xfer_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.sender_req  = '0;
    bus.sender_data = '0;
    bus.rx_enable   = 1'b0;
    bus.rx_ack      = 1'b0;
    repeat (2) tick();
    check("rst_ack", 32'(bus.sender_ack), 0);
    check("rst_rx_req", 32'(bus.rx_req), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_grant", 32'(bus.grant_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.xfer_count), 0);
    reset = 1'b0;

    // Single transfer from sender 2
    bus.rx_enable = 1'b1;
    bus.sender_data[23:16] = 8'hA5;
    bus.sender_req = 4'b0100;
    tick();
    check("t1_rx_req", 32'(bus.rx_req), 1);
    check("t1_rx_data", 32'(bus.rx_data), 32'h A5);
    check("t1_grant", 32'(bus.grant_id), 2);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_no_ack", 32'(bus.sender_ack), 0);
    tick();
    check("t1_wait_ack", 32'(bus.sender_ack), 0);
    bus.rx_ack = 1'b1;
    tick();
    check("t1_ack", 32'(bus.sender_ack), 32'h4);
    bus.sender_req = 4'b0000;
    tick();
    check("t1_rx_req_low", 32'(bus.rx_req), 0);
    check("t1_busy_rel", 32'(bus.busy), 1);
    bus.rx_ack = 1'b0;
    tick();
    check("t1_ack_low", 32'(bus.sender_ack), 0);
    check("t1_busy_low", 32'(bus.busy), 0);
    check("t1_count", 32'(bus.xfer_count), 1);

    // Round-robin with all four senders requesting continuously
    apply_reset();
    check("rr_rst_count", 32'(bus.xfer_count), 0);
    for (int i = 0; i < 4; i++) bus.sender_data[i*8 +: 8] = 8'(8'h10 + i);
    bus.sender_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      xfer(k % 4, 8'(8'h10 + (k % 4)));
      bus.sender_req[k % 4] = 1'b1;
    end
    bus.sender_req = 4'b0000;
    check("rr_count", 32'(bus.xfer_count), 6);
    check("rr_count_wrap", 32'(bus2.xfer_count), 2);

    // Data sampled only at grant
    bus.sender_data[15:8] = 8'h3C;
    bus.sender_req = 4'b0010;
    tick();
    check("hold_grant", 32'(bus.grant_id), 1);
    check("hold_data0", 32'(bus.rx_data), 32'h3C);
    bus.sender_data[15:8] = 8'hFF;
    tick();
    check("hold_data1", 32'(bus.rx_data), 32'h3C);
    bus.rx_ack = 1'b1;
    tick();
    bus.sender_req = 4'b0000;
    tick();
    check("hold_data_rel", 32'(bus.rx_data), 32'h3C);
    bus.rx_ack = 1'b0;
    tick();
    check("hold_data_end", 32'(bus.rx_data), 32'h3C);
    check("hold_count", 32'(bus.xfer_count), 7);

    // Receiver not ready
    bus.rx_enable = 1'b0;
    bus.sender_data[7:0] = 8'h42;
    bus.sender_req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("nr_rx_req", 32'(bus.rx_req), 0);
      check("nr_busy", 32'(bus.busy), 0);
    end
    bus.rx_enable = 1'b1;
    tick();
    check("nr_grant_req", 32'(bus.rx_req), 1);
    check("nr_grant_id", 32'(bus.grant_id), 0);
    check("nr_grant_data", 32'(bus.rx_data), 32'h42);
    bus.rx_ack = 1'b1;
    tick();
    bus.sender_req = 4'b0000;
    tick();
    bus.rx_ack = 1'b0;
    tick();
    check("nr_count", 32'(bus.xfer_count), 8);

    // Granted sender drops req early, while still in REQ
    bus.sender_data[31:24] = 8'h77;
    bus.sender_req = 4'b1000;
    tick();
    check("ed_grant", 32'(bus.grant_id), 3);
    bus.sender_req = 4'b0000;
    tick();
    check("ed_req_held", 32'(bus.rx_req), 1);
    check("ed_no_ack", 32'(bus.sender_ack), 0);
    bus.rx_ack = 1'b1;
    tick();
    check("ed_ack", 32'(bus.sender_ack), 32'h8);
    check("ed_rx_req_still", 32'(bus.rx_req), 1);
    tick();
    check("ed_rx_req_low", 32'(bus.rx_req), 0);
    bus.rx_ack = 1'b0;
    tick();
    check("ed_ack_low", 32'(bus.sender_ack), 0);
    check("ed_count", 32'(bus.xfer_count), 9);
    check("ed_count_wrap", 32'(bus2.xfer_count), 1);

    // Move last_grant to 1 so that sender 0 winning below needs the reset
    bus.sender_data[15:8] = 8'h31;
    bus.sender_req = 4'b0010;
    xfer(1, 8'h31);

    // Reset mid-transfer while in ACK_UP
    bus.sender_data[23:16] = 8'h5A;
    bus.sender_req = 4'b0100;
    tick();
    check("mr_grant", 32'(bus.grant_id), 2);
    bus.rx_ack = 1'b1;
    tick();
    check("mr_ack", 32'(bus.sender_ack), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("mr_rst_ack", 32'(bus.sender_ack), 0);
    check("mr_rst_rx_req", 32'(bus.rx_req), 0);
    check("mr_rst_rx_data", 32'(bus.rx_data), 0);
    check("mr_rst_grant", 32'(bus.grant_id), 0);
    check("mr_rst_busy", 32'(bus.busy), 0);
    check("mr_rst_count", 32'(bus.xfer_count), 0);
    #1;
    reset = 1'b0;
    bus.rx_ack = 1'b0;
    bus.sender_data[7:0] = 8'h0A;
    bus.sender_req = 4'b0101;
    xfer(0, 8'h0A);
    xfer(2, 8'h5A);
    bus.sender_req[1] = 1'b1;
    xfer(1, 8'h31);
    check("wrap_count3", 32'(bus2.xfer_count), 3);
    bus.sender_data[31:24] = 8'h77;
    bus.sender_req[3] = 1'b1;
    xfer(3, 8'h77);
    check("wrap_count_full", 32'(bus.xfer_count), 4);
    check("wrap_count_zero", 32'(bus2.xfer_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
